// File: rtl/telemetry_framer.sv
// Snapshots roll/pitch/yaw on a strobe and serialises them as a byte frame over valid/ready.
// Define TELEM_CRC8_EN to append a CRC-8 (poly 0x07) byte over the six payload bytes.
module telemetry_framer #(
    parameter logic [7:0]  HEADER0 = 8'hDE,
    parameter logic [7:0]  HEADER1 = 8'hAD,
    parameter int unsigned DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  logic [15:0]       roll_in,
    input  logic [15:0]       pitch_in,
    input  logic [15:0]       yaw_in,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [DROP_W-1:0] drop_count
);

`ifdef TELEM_CRC8_EN
    localparam int unsigned NBYTES = 9;
`else
    localparam int unsigned NBYTES = 8;
`endif
    localparam int unsigned     IDX_W    = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    typedef struct packed {
        logic [15:0] roll;
        logic [15:0] pitch;
        logic [15:0] yaw;
    } sample_t;

    state_e            state_q;
    sample_t           act_q;
    sample_t           pend_q;
    logic              pend_valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        byte_data_q;
    logic              byte_valid_q;
    logic              busy_q;
    logic              frame_done_q;
    logic [DROP_W-1:0] drop_q;

    sample_t           sample_c;
    logic              xfer_c;
    logic              last_xfer_c;
    logic [IDX_W-1:0]  idx_inc_c;
    logic [7:0]        next_byte_c;

    // Header and big-endian payload bytes for a given frame position.
    function automatic logic [7:0] frame_byte(input sample_t s, input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(0): frame_byte = HEADER0;
            IDX_W'(1): frame_byte = HEADER1;
            IDX_W'(2): frame_byte = s.roll[15:8];
            IDX_W'(3): frame_byte = s.roll[7:0];
            IDX_W'(4): frame_byte = s.pitch[15:8];
            IDX_W'(5): frame_byte = s.pitch[7:0];
            IDX_W'(6): frame_byte = s.yaw[15:8];
            IDX_W'(7): frame_byte = s.yaw[7:0];
            default:   frame_byte = 8'h00;
        endcase
    endfunction

    assign sample_c    = {roll_in, pitch_in, yaw_in};
    assign xfer_c      = byte_valid_q & byte_ready;
    assign last_xfer_c = xfer_c & (idx_q == LAST_IDX);
    assign idx_inc_c   = idx_q + IDX_W'(1);

`ifdef TELEM_CRC8_EN
    logic [7:0] crc_q;
    logic [7:0] crc_next_c;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] x;
        x = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        crc8_step = x;
    endfunction

    // The CRC byte must already include the last payload byte being accepted now.
    assign crc_next_c  = crc8_step(crc_q, byte_data_q);
    assign next_byte_c = (idx_inc_c == LAST_IDX) ? crc_next_c : frame_byte(act_q, idx_inc_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else if ((state_q == ST_IDLE) || last_xfer_c) begin
            crc_q <= 8'h00;
        end else if (xfer_c && (idx_q >= IDX_W'(2))) begin
            crc_q <= crc_next_c;
        end
    end
`else
    assign next_byte_c = frame_byte(act_q, idx_inc_c);
`endif

    // Frame sequencer: active/pending buffers, byte index and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            idx_q        <= '0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_valid) begin
                        act_q        <= sample_c;
                        idx_q        <= '0;
                        byte_data_q  <= HEADER0;
                        byte_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (last_xfer_c) begin
                        frame_done_q <= 1'b1;
                        idx_q        <= '0;
                        byte_data_q  <= HEADER0;
                        if (pend_valid_q) begin
                            // Pending frame goes out back-to-back; a coincident strobe refills pending.
                            act_q        <= pend_q;
                            pend_valid_q <= frame_valid;
                            if (frame_valid) begin
                                pend_q <= sample_c;
                            end
                        end else if (frame_valid) begin
                            act_q <= sample_c;
                        end else begin
                            state_q      <= ST_IDLE;
                            byte_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end
                    end else begin
                        if (xfer_c) begin
                            idx_q       <= idx_inc_c;
                            byte_data_q <= next_byte_c;
                        end
                        if (frame_valid) begin
                            pend_q       <= sample_c;
                            pend_valid_q <= 1'b1;
                            if (pend_valid_q && (drop_q != '1)) begin
                                drop_q <= drop_q + DROP_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign drop_count = drop_q;

endmodule
